// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the multicycle add/subtract unit.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

   function automatic bit params_legal(input int width, input int chunk);
      return (chunk > 0) && (width % chunk == 0) && (width / chunk >= 2);
   endfunction

endpackage

// File: rtl/addsub_multicycle_cla_chunk.sv
// Combinational carry-lookahead slice: every carry is formed directly from
// generate/propagate terms instead of rippling bit to bit.
module cla_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] s,
   output logic             c_out,
   output logic             c_msb_in
);

   logic [CHUNK-1:0] g;
   logic [CHUNK-1:0] p;
   logic [CHUNK:0]   c;

   // Carry into bit n = OR over j<n of (g[j] & p[n-1..j+1]) | (p[n-1..0] & c_in).
   function automatic logic lookahead(input logic [CHUNK-1:0] gv,
                                      input logic [CHUNK-1:0] pv,
                                      input logic             cin,
                                      input int               n);
      logic cy;
      logic run;
      cy  = 1'b0;
      run = 1'b1;
      for (int j = n - 1; j >= 0; j--) begin
         cy  = cy | (run & gv[j]);
         run = run & pv[j];
      end
      return cy | (run & cin);
   endfunction

   assign g    = a & b;
   assign p    = a ^ b;
   assign c[0] = c_in;

   for (genvar gi = 1; gi <= CHUNK; gi++) begin : g_carry
      assign c[gi] = lookahead(g, p, c_in, gi);
   end

   assign s        = p ^ c[CHUNK-1:0];
   assign c_out    = c[CHUNK];
   assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/addsub_multicycle.sv
// Two's-complement add/subtract that walks a wide operand one CLA slice per
// clock, with registered inter-slice carry, status flags and an accumulator.
module addsub_multicycle
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = idx_width(NCHUNK);
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   if (!params_legal(WIDTH, CHUNK)) begin : g_param_check
      $error("addsub_multicycle: WIDTH must be a multiple of CHUNK with at least two slices");
   end

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] opa_reg;
   logic [WIDTH-1:0] opb_reg;
   logic [WIDTH-1:0] acc_reg;
   logic             cin_reg;
   logic             acc_en_reg;
   logic [IW-1:0]    idx_reg;
   logic [CHUNK-1:0] result_reg [NCHUNK];
   logic             carry_reg;
   logic             ovf_reg;
   logic             zero_reg;
   logic             neg_reg;
   logic             fin_reg;

   logic [CHUNK-1:0] opa_ch [NCHUNK];
   logic [CHUNK-1:0] opb_ch [NCHUNK];
   logic [WIDTH-1:0] result_w;
   logic [CHUNK-1:0] slice_s;
   logic             slice_cout;
   logic             slice_cmsb;

   for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slices
      assign opa_ch[gi]                  = opa_reg[gi*CHUNK +: CHUNK];
      assign opb_ch[gi]                  = opb_reg[gi*CHUNK +: CHUNK];
      assign result_w[gi*CHUNK +: CHUNK] = result_reg[gi];
   end

   cla_chunk #(.CHUNK(CHUNK)) u_cla (
      .a        (opa_ch[idx_reg]),
      .b        (opb_ch[idx_reg]),
      .c_in     (cin_reg),
      .s        (slice_s),
      .c_out    (slice_cout),
      .c_msb_in (slice_cmsb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = CALC;
         CALC:    if (idx_reg == LAST_IDX) state_next = DONE;
         DONE:    if (fin_reg && out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE) && fin_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opa_reg    <= '0;
         opb_reg    <= '0;
         acc_reg    <= '0;
         cin_reg    <= 1'b0;
         acc_en_reg <= 1'b0;
         idx_reg    <= '0;
         carry_reg  <= 1'b0;
         ovf_reg    <= 1'b0;
         zero_reg   <= 1'b0;
         neg_reg    <= 1'b0;
         fin_reg    <= 1'b0;
         for (int i = 0; i < NCHUNK; i++) begin
            result_reg[i] <= '0;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (acc_clr) acc_reg <= '0;
               if (in_valid) begin
                  // A coincident clear wins over the stale accumulator value.
                  opa_reg    <= acc_en ? (acc_clr ? '0 : acc_reg) : a;
                  opb_reg    <= b ^ {WIDTH{sub}};
                  cin_reg    <= sub;
                  acc_en_reg <= acc_en;
                  idx_reg    <= '0;
                  fin_reg    <= 1'b0;
               end
            end
            CALC: begin
               result_reg[idx_reg] <= slice_s;
               cin_reg             <= slice_cout;
               idx_reg             <= idx_reg + 1'b1;
               if (idx_reg == LAST_IDX) begin
                  carry_reg <= slice_cout;
                  ovf_reg   <= slice_cout ^ slice_cmsb;
               end
            end
            DONE: begin
               // Wide zero-detect gets its own cycle so it stays off the slice adder path.
               if (!fin_reg) begin
                  zero_reg <= (result_w == '0);
                  neg_reg  <= result_w[WIDTH-1];
                  fin_reg  <= 1'b1;
               end else if (out_ready) begin
                  if (acc_en_reg) acc_reg <= result_w;
                  fin_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum      = result_w;
   assign carry    = carry_reg;
   assign overflow = ovf_reg;
   assign zero     = zero_reg;
   assign negative = neg_reg;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Directed bench for addsub_multicycle (WIDTH=32, CHUNK=8): hand-computed
// results, flags, latency, stall behaviour, accumulator and mid-op reset.
module tb_addsub_multicycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic        acc_en;
   logic        acc_clr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        carry;
   logic        overflow;
   logic        zero;
   logic        negative;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] r_sum;
   logic        r_c, r_v, r_z, r_n;
   int          r_lat;

   always #5 clk = ~clk;

   addsub_multicycle #(.WIDTH(32), .CHUNK(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .acc_en    (acc_en),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   // Issue one request, wait (bounded) for the result, capture it, then handshake.
   task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic vsub,
                        input logic ven, input logic vclr);
      @(negedge clk);
      a = va; b = vb; sub = vsub; acc_en = ven; acc_clr = vclr; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; acc_clr = 1'b0;
      r_lat = 0;
      while (!out_valid && r_lat < 20) begin
         @(posedge clk); #1;
         r_lat++;
      end
      r_sum = sum; r_c = carry; r_v = overflow; r_z = zero; r_n = negative;
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      $display("op a=%08h b=%08h sub=%0d acc=%0d -> sum=%08h c=%0d v=%0d z=%0d n=%0d lat=%0d",
               va, vb, vsub, ven, r_sum, r_c, r_v, r_z, r_n, r_lat);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      sub = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      vectors++;
      if ({out_valid, in_ready, sum, carry, overflow, zero, negative} !== {1'b0, 1'b1, 32'h0, 4'b0000}) begin
         errors++;
         $display("FAIL reset: got ov=%0d ir=%0d sum=%08h cvzn=%b%b%b%b, want ov=0 ir=1 sum=0 cvzn=0000",
                  out_valid, in_ready, sum, carry, overflow, zero, negative);
      end
   endtask

   task automatic test_add();
      do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      vectors++;
      if ({r_sum, r_c, r_v, r_z, r_n} !== {32'h0000_0100, 4'b0000}) begin
         errors++;
         $display("FAIL add_ff_1: got sum=%08h cvzn=%b%b%b%b, want 00000100 cvzn=0000", r_sum, r_c, r_v, r_z, r_n);
      end
      vectors++;
      if (r_lat !== 5) begin
         errors++;
         $display("FAIL latency: got %0d cycles, want 5", r_lat);
      end
   endtask

   task automatic test_sub();
      do_op(32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
      vectors++;
      if ({r_sum, r_c, r_v, r_z, r_n} !== {32'hFFFF_FFFE, 4'b0001}) begin
         errors++;
         $display("FAIL sub_5_7: got sum=%08h cvzn=%b%b%b%b, want fffffffe cvzn=0001", r_sum, r_c, r_v, r_z, r_n);
      end
      do_op(32'd7, 32'd5, 1'b1, 1'b0, 1'b0);
      vectors++;
      if ({r_sum, r_c, r_v, r_z, r_n} !== {32'h0000_0002, 4'b1000}) begin
         errors++;
         $display("FAIL sub_7_5: got sum=%08h cvzn=%b%b%b%b, want 00000002 cvzn=1000", r_sum, r_c, r_v, r_z, r_n);
      end
   endtask

   task automatic test_overflow();
      do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      vectors++;
      if ({r_sum, r_c, r_v, r_z, r_n} !== {32'h8000_0000, 4'b0101}) begin
         errors++;
         $display("FAIL ovf_add: got sum=%08h cvzn=%b%b%b%b, want 80000000 cvzn=0101", r_sum, r_c, r_v, r_z, r_n);
      end
      do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
      vectors++;
      if ({r_sum, r_c, r_v, r_z, r_n} !== {32'h7FFF_FFFF, 4'b1100}) begin
         errors++;
         $display("FAIL ovf_sub: got sum=%08h cvzn=%b%b%b%b, want 7fffffff cvzn=1100", r_sum, r_c, r_v, r_z, r_n);
      end
   endtask

   task automatic test_ripple();
      do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      vectors++;
      if ({r_sum, r_c, r_v, r_z, r_n} !== {32'h0000_0000, 4'b1010}) begin
         errors++;
         $display("FAIL ripple: got sum=%08h cvzn=%b%b%b%b, want 00000000 cvzn=1010", r_sum, r_c, r_v, r_z, r_n);
      end
   endtask

   task automatic test_accumulate();
      int lat;
      // Clear with a coincident accept: operand A must read as 0, not the old accumulator.
      do_op(32'hDEAD_BEEF, 32'd10, 1'b0, 1'b1, 1'b1);
      vectors++;
      if (r_sum !== 32'd10) begin
         errors++;
         $display("FAIL acc_first: got %08h, want 0000000a", r_sum);
      end
      // Second op, stalled by the consumer for three cycles.
      @(negedge clk);
      a = 32'h1234_5678; b = 32'd20; sub = 1'b0; acc_en = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = (k == 1); a = 32'h5555_5555; b = 32'h1; acc_en = 1'b0;
         @(posedge clk); #1;
         vectors++;
         if ({out_valid, in_ready, sum, carry, overflow, zero, negative} !== {1'b1, 1'b0, 32'd30, 4'b0000}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got ov=%0d ir=%0d sum=%08h cvzn=%b%b%b%b, want ov=1 ir=0 sum=0000001e cvzn=0000",
                     k, out_valid, in_ready, sum, carry, overflow, zero, negative);
         end
      end
      in_valid = 1'b0;
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      $display("op stalled acc add 20 -> sum=0000001e held 3 cycles, lat=%0d", lat);
      do_op(32'h0, 32'd5, 1'b1, 1'b1, 1'b0);
      vectors++;
      if ({r_sum, r_c, r_v, r_z, r_n} !== {32'd25, 4'b1000}) begin
         errors++;
         $display("FAIL acc_final: got sum=%08h cvzn=%b%b%b%b, want 00000019 cvzn=1000", r_sum, r_c, r_v, r_z, r_n);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      a = 32'h0F0F_0F0F; b = 32'h1111_1111; sub = 1'b0; acc_en = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL mid_reset: got ov=%0d ir=%0d sum=%08h, want ov=0 ir=1 sum=00000000", out_valid, in_ready, sum);
      end
      rst = 1'b0;
      $display("reset asserted at slice 2, outputs cleared");
      // Accumulator was 25 before reset; adding 0 in acc mode exposes it.
      do_op(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if ({r_sum, r_z} !== {32'h0, 1'b1}) begin
         errors++;
         $display("FAIL acc_after_reset: got sum=%08h z=%0d, want 00000000 z=1", r_sum, r_z);
      end
      do_op(32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
      vectors++;
      if ({r_sum, r_c, r_v, r_z, r_n} !== {32'd7, 4'b0000}) begin
         errors++;
         $display("FAIL add_3_4: got sum=%08h cvzn=%b%b%b%b, want 00000007 cvzn=0000", r_sum, r_c, r_v, r_z, r_n);
      end
      vectors++;
      if (r_lat !== 5) begin
         errors++;
         $display("FAIL latency_after_reset: got %0d cycles, want 5", r_lat);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_ripple();
      test_accumulate();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
